// File: rtl/mdu_hilo_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_hilo_pkg
// Brief    : Operation encodings, FSM states and decode helpers for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_hilo_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the unit for a latency window (shared with the stall unit)
  function automatic logic is_md_busy_op(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_md_op(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_hilo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_hilo_if
// Brief    : Request/status bundle between the E stage and the MDU.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, hi, lo
  );

endinterface

`default_nettype wire

// File: rtl/mdu_hilo_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_calc
// Brief    : Combinational multiply/divide datapath producing {hi,lo}.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_calc
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [2:0]       i_op,
  input  wire logic [WIDTH-1:0] i_src_a,
  input  wire logic [WIDTH-1:0] i_src_b,
  output logic      [WIDTH-1:0] o_hi,
  output logic      [WIDTH-1:0] o_lo
);

  localparam logic [WIDTH-1:0] c_MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] w_sext_a, w_sext_b, w_zext_a, w_zext_b;
  logic [2*WIDTH-1:0] w_smul, w_umul;
  logic               w_b_zero, w_ovf;
  logic [WIDTH-1:0]   w_sdiv_b, w_udiv_b;
  logic signed [WIDTH-1:0] w_sq, w_sr;
  logic [WIDTH-1:0]   w_uq, w_ur;

  // Low 2W bits of a 2W x 2W product of extended operands give the exact result
  assign w_sext_a = {{WIDTH{i_src_a[WIDTH-1]}}, i_src_a};
  assign w_sext_b = {{WIDTH{i_src_b[WIDTH-1]}}, i_src_b};
  assign w_zext_a = {{WIDTH{1'b0}}, i_src_a};
  assign w_zext_b = {{WIDTH{1'b0}}, i_src_b};
  assign w_smul   = w_sext_a * w_sext_b;
  assign w_umul   = w_zext_a * w_zext_b;

  // MIN_INT / -1 divided by 1 instead yields exactly quotient MIN_INT, remainder 0
  assign w_b_zero = (i_src_b == '0);
  assign w_ovf    = (i_src_a == c_MIN_INT) && (i_src_b == '1);
  assign w_sdiv_b = (w_b_zero || w_ovf) ? WIDTH'(1) : i_src_b;
  assign w_udiv_b = w_b_zero ? WIDTH'(1) : i_src_b;

  assign w_sq = $signed(i_src_a) / $signed(w_sdiv_b);
  assign w_sr = $signed(i_src_a) % $signed(w_sdiv_b);
  assign w_uq = i_src_a / w_udiv_b;
  assign w_ur = i_src_a % w_udiv_b;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = w_smul;
      MD_MULTU: {o_hi, o_lo} = w_umul;
      MD_DIV:   {o_hi, o_lo} = w_b_zero ? {i_src_a, {WIDTH{1'b1}}} : {w_sr, w_sq};
      MD_DIVU:  {o_hi, o_lo} = w_b_zero ? {i_src_a, {WIDTH{1'b1}}} : {w_ur, w_uq};
      default:  {o_hi, o_lo} = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_hilo
// Brief    : Multi-cycle multiply/divide unit with architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  wire logic    clk,
  input  wire logic    reset,
  mdu_hilo_if.slave    bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [WIDTH-1:0]     r_hi, w_hi_nxt;
  logic [WIDTH-1:0]     r_lo, w_lo_nxt;
  logic [2*WIDTH-1:0]   r_pend, w_pend_nxt;
  logic [WIDTH-1:0]     w_calc_hi, w_calc_lo;
  logic [CNT_W-1:0]     w_lat;
  logic                 w_accept;

  mdu_calc #(
    .WIDTH   (WIDTH)
  ) u_calc (
    .i_op    (bus.op),
    .i_src_a (bus.src_a),
    .i_src_b (bus.src_b),
    .o_hi    (w_calc_hi),
    .o_lo    (w_calc_lo)
  );

  assign w_accept = bus.start && !r_busy;
  assign w_lat    = ((bus.op == MD_MULT) || (bus.op == MD_MULTU)) ?
                    CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_md_busy_op(bus.op)) begin
            // Result is frozen at accept so later operand changes cannot leak in
            w_pend_nxt  = {w_calc_hi, w_calc_lo};
            w_cnt_nxt   = w_lat;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (bus.op == MD_MTHI) begin
            w_hi_nxt = bus.src_a;
          end else if (bus.op == MD_MTLO) begin
            w_lo_nxt = bus.src_a;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt <= CNT_W'(1)) begin
          {w_hi_nxt, w_lo_nxt} = r_pend;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mdu_hilo
// Brief    : Directed self-checking bench for mdu_hilo (MULT_LAT=5, DIV_LAT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(
    .WIDTH    (32),
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request now, hold it across one rising edge, then scramble operands
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    bus.src_a = 32'hDEAD_BEEF;
    bus.src_b = 32'h0BAD_F00D;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(op, a, b);
  endtask

  // Counts falling edges that still see busy; ends on the first one that does not
  task automatic wait_done(input int exp_n, input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (n > 100) break;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    bus.src_a = '0;
    bus.src_b = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    reset = 1'b0;

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.src_a = 32'h0000_AAAA;
    @(posedge clk);
    #1;
    chk("mthi_hi", bus.hi, 32'h0000_AAAA);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    bus.op    = OP_MTLO;
    bus.src_a = 32'h0000_5555;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h0000_5555);
    chk("mtlo_hi_kept", bus.hi, 32'h0000_AAAA);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);

    // NOP and the unused code do nothing
    issue(OP_NOP, 32'h1111_1111, 32'h1);
    issue(OP_RSVD, 32'h2222_2222, 32'h2);
    @(negedge clk);
    chk("nop_hi", bus.hi, 32'h0000_AAAA);
    chk("nop_lo", bus.lo, 32'h0000_5555);
    chk("nop_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a MULT discards it
    issue(OP_MULT, 32'd3, 32'd4);
    chk("rstmid_busy_on", 32'(bus.busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_hi", bus.hi, 32'd0);
    chk("rstmid_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstmid_nocommit_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_nocommit_lo", bus.lo, 32'd0);
    chk("rstmid_nocommit_hi", bus.hi, 32'd0);

    // Signed MULT, with a stale-read check one cycle into the run
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    chk("mult_stale_hi", bus.hi, 32'd0);
    wait_done(4, "mult_lat_rest");
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFE);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(5, "multu_lat");
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(10, "div_lat");
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(10, "divu0_lat");
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd7);

    // Signed overflow, plus an MTHI that arrives while busy and must be dropped
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    wait_done(9, "ovf_lat_rest");
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'd0);

    // Back-to-back: next request in the first cycle busy is low
    issue(OP_MULT, 32'd6, 32'd7);
    wait_done(5, "b2b_mult_lat");
    chk("b2b_mult_lo", bus.lo, 32'd42);
    chk("b2b_mult_hi", bus.hi, 32'd0);
    drive(OP_DIVU, 32'd100, 32'd7);
    chk("b2b_divu_busy", 32'(bus.busy), 32'd1);
    wait_done(10, "b2b_divu_lat");
    chk("b2b_divu_lo", bus.lo, 32'd14);
    chk("b2b_divu_hi", bus.hi, 32'd2);
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_hi", bus.hi, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
